// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter that hands a single shared bus to one of NREQ
// requesters at a time. The owner's write data is driven onto bus_a and the
// shared return data (bus_b) is broadcast to everybody on rdata. Ownership is
// held until the owner signals done, drops its request, or the watchdog runs
// out. Every release is followed by exactly one bubble cycle with no grant.
//
// Parameters
//   NREQ     number of requesters (>= 1)
//   WIDTH    bus data width
//   TIMEOUT  maximum cycles per ownership, 0 disables the watchdog
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous reset, active-high
//   req        in   [NREQ]        request per requester
//   done       in   [NREQ]        end-of-transfer per requester (owner's bit only)
//   wdata      in   [NREQ*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   bus_b      in   [WIDTH]       return data from the shared bus
//   gnt        out  [NREQ]        one-hot grant, registered
//   bus_a      out  [WIDTH]       owner's wdata, 0 when no owner
//   bus_valid  out                high while an owner holds the bus
//   rdata      out  [WIDTH]       bus_b, passed through combinationally
//   owner_id   out  [IDW]         index of current / last owner
//   timeout    out                one-cycle pulse when the watchdog forced release
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       done,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0]      bus_b,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      bus_a,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      rdata,
    output logic [IDW-1:0]        owner_id,
    output logic                  timeout
);

    // Timer only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            bus_valid_q;
    logic [IDW-1:0]  owner_q;
    logic [IDW-1:0]  ptr_q;
    logic [TW-1:0]   timer_q;
    logic            timeout_q;

    // Per-requester data slices
    logic [WIDTH-1:0] wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin winner: first set request scanning from ptr+1, wrapping.
    // Starting the scan one past the last owner is what keeps the previous
    // owner from winning again while anyone else is waiting.
    logic           any_req;
    logic           found;
    logic [IDW-1:0] win_d;
    logic [IDW-1:0] scan_idx;
    int             idx;

    always_comb begin
        any_req  = |req;
        found    = 1'b0;
        win_d    = '0;
        scan_idx = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx      = (int'(ptr_q) + k) % NREQ;
            scan_idx = IDW'(idx);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win_d = scan_idx;
            end
        end
    end

    // Owner-qualified release conditions; other requesters' bits are ignored.
    logic own_done;
    logic own_req;
    logic wd_expire;

    assign own_done = done[owner_q];
    assign own_req  = req[owner_q];

    generate
        if (TIMEOUT > 0) begin : g_wd
            assign wd_expire = (timer_q == TW'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            bus_valid_q <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            timer_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RELEASE: begin
                    if (any_req) begin
                        state_q     <= ST_OWNED;
                        gnt_q       <= NREQ'(1) << win_d;
                        bus_valid_q <= 1'b1;
                        owner_q     <= win_d;
                        ptr_q       <= win_d;
                        timer_q     <= '0;
                    end else begin
                        state_q     <= ST_IDLE;
                        gnt_q       <= '0;
                        bus_valid_q <= 1'b0;
                    end
                end
                ST_OWNED: begin
                    if (own_done || !own_req || wd_expire) begin
                        state_q     <= ST_RELEASE;
                        gnt_q       <= '0;
                        bus_valid_q <= 1'b0;
                        // Flag only releases that the watchdog alone caused.
                        timeout_q   <= wd_expire && own_req && !own_done;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    gnt_q       <= '0;
                    bus_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign bus_valid = bus_valid_q;
    assign owner_id  = owner_q;
    assign timeout   = timeout_q;
    assign bus_a     = bus_valid_q ? wdata_arr[owner_q] : '0;
    assign rdata     = bus_b;

endmodule
